// File: rtl/fft_butterfly_operand_fetch_if.sv
// Handshake and memory-port bundle for the FFT butterfly operand fetcher.
// The master is the fetch unit; the slave is the memory/butterfly environment.
interface fft_butterfly_operand_fetch_if #(
  parameter int unsigned N_LOG2 = 5,
  parameter int unsigned MEM_W  = 24
);
  localparam int unsigned TwW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

  logic              start;
  logic [1:0]        precision_mode;
  logic              mem_rd_en;
  logic [N_LOG2-1:0] mem_rd_addr_a;
  logic [N_LOG2-1:0] mem_rd_addr_b;
  logic [MEM_W-1:0]  mem_rd_data_a;
  logic [MEM_W-1:0]  mem_rd_data_b;
  logic [TwW-1:0]    tw_addr;
  logic [MEM_W-1:0]  tw_data;
  logic              wb_idle;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_a;
  logic [15:0]       out_b;
  logic [15:0]       out_w;
  logic [N_LOG2-1:0] out_addr_a;
  logic [N_LOG2-1:0] out_addr_b;
  logic [1:0]        out_mode;
  logic              busy;
  logic              done;

  modport master (
    input  start, precision_mode, mem_rd_data_a, mem_rd_data_b, tw_data, wb_idle, out_ready,
    output mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr, out_valid, out_a, out_b, out_w,
           out_addr_a, out_addr_b, out_mode, busy, done
  );

  modport slave (
    output start, precision_mode, mem_rd_data_a, mem_rd_data_b, tw_data, wb_idle, out_ready,
    input  mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr, out_valid, out_a, out_b, out_w,
           out_addr_a, out_addr_b, out_mode, busy, done
  );
endinterface

// File: rtl/fft_butterfly_operand_fetch.sv
// Radix-2 in-place DIT FFT sequencer: walks stages/butterflies, fetches A/B/twiddle words and
// unpacks them into operands for the selected butterfly precision, one butterfly at a time.
module fft_butterfly_operand_fetch #(
  parameter int unsigned N_LOG2 = 5,
  parameter int unsigned MEM_W  = 24
) (
  input logic clk,
  input logic rst_n,
  fft_butterfly_operand_fetch_if.master bus
);
  localparam int unsigned TwW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam int unsigned SW  = $clog2(N_LOG2) + 1;
  localparam logic [TwW-1:0] JLast = TwW'((1 << N_LOG2) / 2 - 1);
  localparam logic [SW-1:0]  SLast = SW'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] One = N_LOG2'(1);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StOut, StDrain} state_e;

  state_e            r_state, w_state_nxt;
  logic [SW-1:0]     r_s, w_s_nxt;
  logic [TwW-1:0]    r_j, w_j_nxt;
  logic              r_drain_wait, w_drain_wait_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic              r_done, w_done_nxt;
  logic [15:0]       r_out_a, w_out_a_nxt;
  logic [15:0]       r_out_b, w_out_b_nxt;
  logic [15:0]       r_out_w, w_out_w_nxt;
  logic [N_LOG2-1:0] r_out_addr_a, w_out_addr_a_nxt;
  logic [N_LOG2-1:0] r_out_addr_b, w_out_addr_b_nxt;

  logic [N_LOG2-1:0] w_j_ext, w_half, w_pos, w_addr_a, w_addr_b, w_k_full;
  logic              w_rd_en, w_add_fp8, w_mul_fp8;

  // Butterfly addressing for stage s: groups of 2*half, A in the lower half, B in the upper.
  always_comb begin
    w_j_ext  = N_LOG2'(r_j);
    w_half   = One << r_s;
    w_pos    = w_j_ext & (w_half - One);
    w_addr_a = ((w_j_ext >> r_s) << (r_s + 1'b1)) | w_pos;
    w_addr_b = w_addr_a + w_half;
    w_k_full = w_pos << (N_LOG2'(N_LOG2 - 1) - N_LOG2'(r_s));
  end

  // Adder operands are FP8 in modes 00/11; multiplier operands are FP8 in modes 00/10.
  assign w_add_fp8 = (r_mode[1] == r_mode[0]);
  assign w_mul_fp8 = ~r_mode[0];
  assign w_rd_en   = (r_state == StRd);

  always_comb begin
    w_state_nxt      = r_state;
    w_s_nxt          = r_s;
    w_j_nxt          = r_j;
    w_drain_wait_nxt = r_drain_wait;
    w_mode_nxt       = r_mode;
    w_done_nxt       = 1'b0;
    w_out_a_nxt      = r_out_a;
    w_out_b_nxt      = r_out_b;
    w_out_w_nxt      = r_out_w;
    w_out_addr_a_nxt = r_out_addr_a;
    w_out_addr_b_nxt = r_out_addr_b;
    unique case (r_state)
      StIdle: begin
        if (bus.start && !r_done) begin
          w_mode_nxt  = bus.precision_mode;
          w_s_nxt     = '0;
          w_j_nxt     = '0;
          w_state_nxt = StRd;
        end
      end
      StRd: w_state_nxt = StCap;
      StCap: begin
        w_out_a_nxt = w_add_fp8 ? bus.mem_rd_data_a[MEM_W-1 -: 16]
                                : {8'h00, bus.mem_rd_data_a[7:0]};
        w_out_b_nxt = w_mul_fp8 ? bus.mem_rd_data_b[MEM_W-1 -: 16]
                                : {8'h00, bus.mem_rd_data_b[7:0]};
        w_out_w_nxt = w_mul_fp8 ? bus.tw_data[MEM_W-1 -: 16]
                                : {8'h00, bus.tw_data[7:0]};
        w_out_addr_a_nxt = w_addr_a;
        w_out_addr_b_nxt = w_addr_b;
        w_state_nxt      = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          if (r_j == JLast) begin
            w_drain_wait_nxt = 1'b1;
            w_state_nxt      = StDrain;
          end else begin
            w_j_nxt     = r_j + 1'b1;
            w_state_nxt = StRd;
          end
        end
      end
      StDrain: begin
        // First drain cycle ignores wb_idle so the last write of the stage can land.
        if (r_drain_wait) begin
          w_drain_wait_nxt = 1'b0;
        end else if (bus.wb_idle) begin
          if (r_s == SLast) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_s_nxt     = r_s + 1'b1;
            w_j_nxt     = '0;
            w_state_nxt = StRd;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_s          <= '0;
      r_j          <= '0;
      r_drain_wait <= 1'b0;
      r_mode       <= 2'b00;
      r_done       <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_w      <= '0;
      r_out_addr_a <= '0;
      r_out_addr_b <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_s          <= w_s_nxt;
      r_j          <= w_j_nxt;
      r_drain_wait <= w_drain_wait_nxt;
      r_mode       <= w_mode_nxt;
      r_done       <= w_done_nxt;
      r_out_a      <= w_out_a_nxt;
      r_out_b      <= w_out_b_nxt;
      r_out_w      <= w_out_w_nxt;
      r_out_addr_a <= w_out_addr_a_nxt;
      r_out_addr_b <= w_out_addr_b_nxt;
    end
  end

  assign bus.mem_rd_en     = w_rd_en;
  assign bus.mem_rd_addr_a = w_rd_en ? w_addr_a : '0;
  assign bus.mem_rd_addr_b = w_rd_en ? w_addr_b : '0;
  assign bus.tw_addr       = w_rd_en ? TwW'(w_k_full) : '0;
  assign bus.out_valid     = (r_state == StOut);
  assign bus.out_a         = r_out_a;
  assign bus.out_b         = r_out_b;
  assign bus.out_w         = r_out_w;
  assign bus.out_addr_a    = r_out_addr_a;
  assign bus.out_addr_b    = r_out_addr_b;
  assign bus.out_mode      = r_mode;
  assign bus.busy          = (r_state != StIdle);
  assign bus.done          = r_done;
endmodule

// File: tb/tb_fft_butterfly_operand_fetch.sv
// Scoreboard bench: a stage/group/offset reference model queues expected reads and operands,
// monitors on the falling edge pop and compare whatever the fetch unit presents.
module tb_fft_butterfly_operand_fetch;
  localparam int unsigned NL = 3;
  localparam int unsigned N  = 1 << NL;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_butterfly_operand_fetch_if #(.N_LOG2(NL), .MEM_W(24)) bus ();
  fft_butterfly_operand_fetch #(.N_LOG2(NL), .MEM_W(24)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NL-1:0] a;
    logic [NL-1:0] b;
    logic [NL-2:0] k;
  } rd_t;
  typedef struct packed {
    logic [15:0]   a;
    logic [15:0]   b;
    logic [15:0]   w;
    logic [NL-1:0] xa;
    logic [NL-1:0] xb;
    logic [1:0]    m;
  } out_t;

  rd_t   exp_rd[$];
  out_t  exp_out[$];
  int    rd_cycles[$];
  int    hs_cycles[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    first_valid = -1;
  int    start_cyc = 0;
  logic [23:0] mem [N];
  logic [23:0] rom [N/2];
  bit    fixed_words;
  bit    prev_pend;
  out_t  prev_snap;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory / twiddle ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data_a <= fixed_words ? 24'h3C4D5A : mem[bus.mem_rd_addr_a];
      bus.mem_rd_data_b <= fixed_words ? 24'h112233 : mem[bus.mem_rd_addr_b];
      bus.tw_data       <= fixed_words ? 24'h7F00C3 : rom[bus.tw_addr];
    end
  end

  function automatic out_t ref_out(input logic [1:0] m, input int a, input int b, input int k);
    out_t o;
    logic [23:0] wa, wb, wt;
    bit add8, mul8;
    o.xa = NL'(a);
    o.xb = NL'(b);
    o.m  = m;
    if (fixed_words) begin
      case (m)
        2'b00:   {o.a, o.b, o.w} = {16'h3C4D, 16'h1122, 16'h7F00};
        2'b01:   {o.a, o.b, o.w} = {16'h005A, 16'h0033, 16'h00C3};
        2'b10:   {o.a, o.b, o.w} = {16'h005A, 16'h1122, 16'h7F00};
        default: {o.a, o.b, o.w} = {16'h3C4D, 16'h0033, 16'h00C3};
      endcase
    end else begin
      wa = mem[a];
      wb = mem[b];
      wt = rom[k];
      add8 = (m == 2'b00) || (m == 2'b11);
      mul8 = (m == 2'b00) || (m == 2'b10);
      o.a = add8 ? wa[23:8] : {8'h00, wa[7:0]};
      o.b = mul8 ? wb[23:8] : {8'h00, wb[7:0]};
      o.w = mul8 ? wt[23:8] : {8'h00, wt[7:0]};
    end
    return o;
  endfunction

  // Textbook DIT ordering: per stage, groups of 2*span, offset p inside a group.
  task automatic push_run(input logic [1:0] m);
    for (int s = 0; s < int'(NL); s++) begin
      int span = 1 << s;
      int tstep = int'(N) / (2 * span);
      for (int g = 0; g < int'(N); g += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          rd_t r;
          r.a = NL'(g + p);
          r.b = NL'(g + p + span);
          r.k = (NL-1)'(p * tstep);
          exp_rd.push_back(r);
          exp_out.push_back(ref_out(m, g + p, g + p + span, p * tstep));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    out_t cur;
    out_t e;
    rd_t  r;
    cur.a  = bus.out_a;
    cur.b  = bus.out_b;
    cur.w  = bus.out_w;
    cur.xa = bus.out_addr_a;
    cur.xb = bus.out_addr_b;
    cur.m  = bus.out_mode;
    if (rst_n) begin
      if (prev_pend) begin
        chk("out_valid_held", longint'(bus.out_valid), 1);
        chk("out_stable", longint'(cur), longint'(prev_snap));
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("rd_during_out", longint'(bus.mem_rd_en), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cycles.push_back(cyc);
        if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          e = exp_out.pop_front();
          chk("out_fields", longint'(cur), longint'(e));
        end
      end
      if (bus.mem_rd_en) begin
        r.a = bus.mem_rd_addr_a;
        r.b = bus.mem_rd_addr_b;
        r.k = bus.tw_addr;
        rd_cycles.push_back(cyc);
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr_abk", longint'(r), longint'(exp_rd.pop_front()));
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_queue_empty", exp_out.size(), 0);
      end
    end
    prev_pend = rst_n && bus.out_valid && !bus.out_ready;
    prev_snap = cur;
  end

  task automatic check_all_zero(input string p);
    chk({p, "_rd_en"}, longint'(bus.mem_rd_en), 0);
    chk({p, "_rd_addrs"}, longint'({bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.tw_addr}), 0);
    chk({p, "_out_valid"}, longint'(bus.out_valid), 0);
    chk({p, "_busy"}, longint'(bus.busy), 0);
    chk({p, "_done"}, longint'(bus.done), 0);
    chk({p, "_out_abw"}, longint'({bus.out_a, bus.out_b, bus.out_w}), 0);
    chk({p, "_out_addr"}, longint'({bus.out_addr_a, bus.out_addr_b}), 0);
    chk({p, "_out_mode"}, longint'(bus.out_mode), 0);
  endtask

  task automatic begin_run(input logic [1:0] m, input bit fixed);
    fixed_words = fixed;
    if (!fixed) begin
      for (int i = 0; i < int'(N); i++) mem[i] = 24'($urandom);
      for (int i = 0; i < int'(N / 2); i++) rom[i] = 24'($urandom);
    end
    push_run(m);
    hs_cycles.delete();
    rd_cycles.delete();
    first_valid = -1;
    bus.precision_mode = m;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.precision_mode = ~m;
  endtask

  task automatic end_run(input bit rnd, input int stray_at, input int budget);
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < budget) begin
      if (rnd) begin
        bus.out_ready = ($urandom_range(0, 1) == 1);
        bus.wb_idle   = ($urandom_range(0, 3) != 0);
      end
      bus.start = (stray_at > 0) && (t == stray_at);
      @(posedge clk); #1;
      t++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb_idle = 1'b1;
    chk("done_within_budget", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("busy_after_done", longint'(bus.busy), 0);
    chk("rd_left_over", exp_rd.size(), 0);
    chk("out_left_over", exp_out.size(), 0);
    exp_rd.delete();
    exp_out.delete();
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (hs_cycles.size() < n && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_handshakes", longint'(hs_cycles.size() >= n), 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_out_valid", longint'(bus.out_valid), 1);
  endtask

  initial begin
    int n0;
    int w;
    int t;
    logic [1:0] m;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.precision_mode = 2'b00;
    bus.out_ready = 1'b1;
    bus.wb_idle = 1'b1;
    fixed_words = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed words, mode 00, free-running: sequence, latency, throughput, drain length.
    begin_run(2'b00, 1'b1);
    end_run(1'b0, 0, 2000);
    chk("handshake_count", hs_cycles.size(), 12);
    chk("start_to_valid", first_valid - start_cyc, 3);
    chk("throughput", hs_cycles[1] - hs_cycles[0], 3);
    chk("hs_to_next_rd", rd_cycles[1] - hs_cycles[0], 1);
    chk("drain_two_cycles", rd_cycles[4] - hs_cycles[3], 3);

    // Remaining unpack modes; a stray start with a different mode lands mid-run in mode 01.
    begin_run(2'b01, 1'b1);
    end_run(1'b0, 4, 2000);
    begin_run(2'b10, 1'b1);
    end_run(1'b0, 0, 2000);
    begin_run(2'b11, 1'b1);
    end_run(1'b0, 0, 2000);

    // Backpressure on the first butterfly.
    bus.out_ready = 1'b0;
    begin_run(2'b00, 1'b0);
    wait_valid();
    n0 = rd_cycles.size();
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_rd", rd_cycles.size(), n0);
    chk("stall_no_hs", hs_cycles.size(), 0);
    chk("stall_valid", longint'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    end_run(1'b0, 0, 2000);

    // Write-back not idle at the stage-0 boundary.
    bus.wb_idle = 1'b0;
    begin_run(2'b11, 1'b0);
    wait_hs(4);
    repeat (10) @(posedge clk);
    #1;
    chk("drain_hold_no_rd", rd_cycles.size(), 4);
    chk("drain_hold_busy", longint'(bus.busy), 1);
    bus.wb_idle = 1'b1;
    w = cyc;
    t = 0;
    while (rd_cycles.size() < 5 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (rd_cycles.size() >= 5) chk("drain_release", rd_cycles[4] - w, 1);
    else chk("drain_release_timeout", 0, 1);
    end_run(1'b0, 0, 2000);

    // Asynchronous reset while stalled in OUT during stage 1, then a fresh run.
    begin_run(2'b10, 1'b0);
    wait_hs(5);
    bus.out_ready = 1'b0;
    wait_valid();
    #2;
    rst_n = 1'b0;
    exp_rd.delete();
    exp_out.delete();
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    begin_run(2'b00, 1'b0);
    end_run(1'b0, 0, 2000);

    // Random data, modes, backpressure and write-back idleness.
    for (int i = 0; i < 4; i++) begin
      m = 2'($urandom_range(0, 3));
      begin_run(m, 1'b0);
      end_run(1'b1, (i == 1) ? 7 : 0, 4000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end
endmodule
